ofdm_tx_stream_scheduler: RTL
=============================

OFDM_TX_STREAM_SCHEDULER -- requirements
Module: ofdm_tx_stream_scheduler

Interface
REQ-001 SHALL have parameter C_AXIS_TDATA_WIDTH, default 32: data width of all stream ports.
REQ-002 SHALL have parameter C_MAX_SYMBOL_WORDS, default 32: maximum beats per output packet.
REQ-003 SHALL have parameter C_GAP_CYCLES, default 4: idle cycles inserted after each output packet (0 legal).
REQ-004 SHALL have port aclk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port aresetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  in  1  level; scheduler may start new packets only while high.
REQ-007 SHALL have ports s00_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/W/1  preamble/pilot source stream.
REQ-008 SHALL have ports s01_axis_tvalid/tready/tdata/tlast  in/out/in/in  1/1/W/1  payload source stream (input buffer).
REQ-009 SHALL have ports m00_axis_tvalid/tready/tdata/tlast  out/in/out/out  1/1/W/1  merged stream to OFDM modulator.
REQ-010 SHALL have port busy  out  1  high when state is not IDLE.
REQ-011 SHALL have port frame_count  out  16  packets completed on m00, wraps 0xFFFF->0.
REQ-012 SHALL have port overlength_err  out  1  sticky; set when a packet is truncated.

Function
REQ-013 SHALL implement FSM states IDLE, XFER, GAP.
REQ-014 IDLE: if enable=1 and any sN_axis_tvalid=1, SHALL register grant and move to XFER next cycle; no beat moves in IDLE.
REQ-015 Arbitration SHALL be round-robin on packet boundaries: both valid -> grant port not granted last; single valid -> grant it.
REQ-016 XFER: m00 tvalid/tdata SHALL mirror granted input combinationally; granted tready = m00_axis_tready; non-granted tready = 0.
REQ-017 Outside XFER, m00_axis_tvalid and both s tready SHALL be 0.
REQ-018 Beat counter SHALL increment on each m00 handshake, cleared on entry to XFER.
REQ-019 m00_axis_tlast SHALL be granted tlast OR (beat count = C_MAX_SYMBOL_WORDS-1).
REQ-020 Handshake with m00_axis_tlast=1 SHALL end packet: frame_count+1, last_grant updated, go to GAP (or IDLE if C_GAP_CYCLES=0).
REQ-021 Forced tlast without source tlast SHALL set overlength_err; remaining source beats form a new packet under normal arbitration.
REQ-022 GAP SHALL last exactly C_GAP_CYCLES cycles, then IDLE.
REQ-023 enable falling during XFER or GAP SHALL NOT abort; current packet completes, then scheduler stays IDLE.
REQ-024 m00_axis_tready low SHALL stall indefinitely without dropping or duplicating beats; tdata held stable while tvalid high.
REQ-025 Source dropping tvalid mid-packet SHALL hold XFER (no timeout).

Reset
REQ-026 On aresetn=0, SHALL asynchronously force state IDLE, last_grant=port 1 (so port 0 wins first tie), beat count 0, frame_count 0, overlength_err 0, busy 0, m00_axis_tvalid 0, all s tready 0.
REQ-027 Reset mid-packet SHALL discard the packet without incrementing frame_count; first cycle after release is IDLE.

Structure
REQ-028 State encoding, grant index type and beat-count width (clog2 of C_MAX_SYMBOL_WORDS) SHALL live in shared package ofdm_tx_pkg.
REQ-029 Arbiter SHALL be one sub-module ofdm_tx_rr_arbiter (2 requests, last_grant in, grant out); remainder flat.

Verification
REQ-030 Reset, enable=1, only s00 sends 4 beats 0xA0..0xA3 with tlast on 4th, m00 tready=1 -> m00 emits same 4 beats one cycle after request, tlast on 0xA3, frame_count=1, 4 GAP cycles then IDLE.
REQ-031 Both sources valid continuously, 2-beat packets each -> output alternates s00,s01,s00,... packets, never interleaved within a packet.
REQ-032 s01 sends 40 beats, tlast only on 40th -> two packets of 32 and 8 beats, overlength_err=1, frame_count +2.
REQ-033 m00 tready toggling every cycle (10 ns clock, 20 ns toggle) during 8-beat packet -> 8 beats delivered in order, no loss/duplication.
REQ-034 enable deasserted on beat 2 of 6 -> all 6 beats delivered, then no new grant although s00/s01 valid.
REQ-035 aresetn pulsed low on beat 3 of 6 -> outputs take reset values immediately, frame_count=0, next packet after release starts cleanly from s00.

Source files
------------

// File: rtl/ofdm_tx_pkg.sv
// rtl/ofdm_tx_pkg.sv - shared state, grant and counter-width definitions for the OFDM TX scheduler
package ofdm_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

    typedef logic grant_t;

    localparam grant_t GRANT_S00 = 1'b0;
    localparam grant_t GRANT_S01 = 1'b1;

    localparam int MAX_SYMBOL_WORDS_DEF = 32;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BEAT_CNT_W = cnt_width(MAX_SYMBOL_WORDS_DEF);

    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

endpackage

// File: rtl/ofdm_tx_rr_arbiter.sv
// rtl/ofdm_tx_rr_arbiter.sv - two-request round-robin arbiter evaluated at packet boundaries
module ofdm_tx_rr_arbiter
    import ofdm_tx_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output grant_t     grant,
    output logic       grant_valid
);

    always_comb begin
        grant_valid = |req;
        grant       = GRANT_S00;
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = GRANT_S01;
        end
    end

endmodule

// File: rtl/ofdm_tx_stream_scheduler.sv
// rtl/ofdm_tx_stream_scheduler.sv - merges preamble/pilot and payload streams into packets for the OFDM modulator
module ofdm_tx_stream_scheduler
    import ofdm_tx_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_MAX_SYMBOL_WORDS = MAX_SYMBOL_WORDS_DEF,
    parameter int C_GAP_CYCLES       = 4
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          enable,

    input  logic                          s00_axis_tvalid,
    output logic                          s00_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
    input  logic                          s00_axis_tlast,

    input  logic                          s01_axis_tvalid,
    output logic                          s01_axis_tready,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s01_axis_tdata,
    input  logic                          s01_axis_tlast,

    output logic                          m00_axis_tvalid,
    input  logic                          m00_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
    output logic                          m00_axis_tlast,

    output logic                          busy,
    output logic [15:0]                   frame_count,
    output logic                          overlength_err
);

    localparam int CNT_W = cnt_width(C_MAX_SYMBOL_WORDS);
    localparam int GAP_W = cnt_width(C_GAP_CYCLES);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(C_MAX_SYMBOL_WORDS - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((C_GAP_CYCLES > 0) ? C_GAP_CYCLES - 1 : 0);

    sched_state_t     state;
    grant_t           grant;
    grant_t           last_grant;
    grant_t           arb_grant;
    logic             arb_valid;
    logic [CNT_W-1:0] beat_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             in_xfer;
    logic             src_tvalid;
    logic             src_tlast;
    logic             hs;

    ofdm_tx_rr_arbiter u_arbiter (
        .req         ({s01_axis_tvalid, s00_axis_tvalid}),
        .last_grant  (last_grant),
        .grant       (arb_grant),
        .grant_valid (arb_valid)
    );

    // The granted source is steered straight through; only XFER opens the path.
    always_comb begin
        in_xfer         = (state == ST_XFER);
        src_tvalid      = (grant == GRANT_S01) ? s01_axis_tvalid : s00_axis_tvalid;
        src_tlast       = (grant == GRANT_S01) ? s01_axis_tlast  : s00_axis_tlast;
        m00_axis_tdata  = (grant == GRANT_S01) ? s01_axis_tdata  : s00_axis_tdata;
        m00_axis_tvalid = in_xfer & src_tvalid;
        m00_axis_tlast  = in_xfer & (src_tlast | (beat_cnt == BEAT_LAST));
        s00_axis_tready = in_xfer & (grant == GRANT_S00) & m00_axis_tready;
        s01_axis_tready = in_xfer & (grant == GRANT_S01) & m00_axis_tready;
        hs              = m00_axis_tvalid & m00_axis_tready;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= ST_IDLE;
            grant          <= GRANT_S00;
            last_grant     <= GRANT_S01;
            beat_cnt       <= '0;
            gap_cnt        <= '0;
            frame_count    <= '0;
            overlength_err <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && arb_valid) begin
                        grant    <= arb_grant;
                        beat_cnt <= '0;
                        state    <= ST_XFER;
                        busy     <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (hs) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (m00_axis_tlast) begin
                            frame_count <= frame_count + 16'd1;
                            last_grant  <= grant;
                            gap_cnt     <= '0;
                            // Truncated packet: the rest of the source packet is re-arbitrated later.
                            if (!src_tlast) begin
                                overlength_err <= 1'b1;
                            end
                            if (C_GAP_CYCLES == 0) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    gap_cnt <= gap_cnt + GAP_W'(1);
                    if (gap_cnt == GAP_LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
